// File: rtl/display_frame_ctrl.sv
// display_frame_ctrl: double-buffered 8x8 RGB frame store with frame-aligned swap.
// Optional column scrolling is enabled by defining DISPLAY_FRAME_CTRL_SCROLL_EN.
module display_frame_ctrl #(
    parameter int SCROLL_PERIOD = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_col,
    input  logic [2:0] wr_row,
    input  logic [2:0] wr_rgb,
    input  logic       clear_req,
    input  logic       commit_req,
    output logic       commit_done,
    input  logic [2:0] col_num,
    input  logic       col_data_capture,
    output logic [7:0] red_vect_out,
    output logic [7:0] green_vect_out,
    output logic [7:0] blue_vect_out,
    output logic       frame_sync
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_SWAP
    } state_t;

    state_t     state;
    logic       front_sel;
    logic       back_sel;
    logic [2:0] clr_idx;
    logic [2:0] offset;
    logic [2:0] rd_col;
    logic       frame_end;

    logic [7:0] mem_r [2][8];
    logic [7:0] mem_g [2][8];
    logic [7:0] mem_b [2][8];

    assign back_sel   = ~front_sel;
    assign frame_end  = col_data_capture && (col_num == 3'd7);
    assign frame_sync = frame_end;
    assign wr_ready   = (state == S_IDLE) && !rst;

    // Front-buffer column mux, shifted by the scroll offset
    assign rd_col         = col_num - offset;
    assign red_vect_out   = mem_r[front_sel][rd_col];
    assign green_vect_out = mem_g[front_sel][rd_col];
    assign blue_vect_out  = mem_b[front_sel][rd_col];

    // Control FSM: pixel writes, back-buffer clear and frame-aligned swap
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            front_sel   <= 1'b0;
            clr_idx     <= 3'd0;
            commit_done <= 1'b0;
            for (int c = 0; c < 8; c++) begin
                for (int b = 0; b < 2; b++) begin
                    mem_r[b][c] <= 8'h00;
                    mem_g[b][c] <= 8'h00;
                    mem_b[b][c] <= 8'h00;
                end
            end
        end else begin
            commit_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (wr_valid) begin
                        mem_r[back_sel][wr_col][wr_row] <= wr_rgb[2];
                        mem_g[back_sel][wr_col][wr_row] <= wr_rgb[1];
                        mem_b[back_sel][wr_col][wr_row] <= wr_rgb[0];
                    end
                    if (clear_req) begin
                        clr_idx <= 3'd0;
                        state   <= S_CLEAR;
                    end else if (commit_req) begin
                        state <= S_WAIT_SWAP;
                    end
                end
                S_CLEAR: begin
                    mem_r[back_sel][clr_idx] <= 8'h00;
                    mem_g[back_sel][clr_idx] <= 8'h00;
                    mem_b[back_sel][clr_idx] <= 8'h00;
                    clr_idx <= clr_idx + 3'd1;
                    if (clr_idx == 3'd7) begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT_SWAP: begin
                    if (frame_end) begin
                        // Old back becomes front; its image is copied into the
                        // new back so drawing continues from what is shown.
                        front_sel <= back_sel;
                        for (int c = 0; c < 8; c++) begin
                            mem_r[front_sel][c] <= mem_r[back_sel][c];
                            mem_g[front_sel][c] <= mem_g[back_sel][c];
                            mem_b[front_sel][c] <= mem_b[back_sel][c];
                        end
                        commit_done <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DISPLAY_FRAME_CTRL_SCROLL_EN
    localparam int CNT_W = (SCROLL_PERIOD > 1) ? $clog2(SCROLL_PERIOD) : 1;

    logic [CNT_W-1:0] scroll_cnt;

    // Scroll timer: advance the display offset one column per period
    always_ff @(posedge clk) begin
        if (rst) begin
            scroll_cnt <= '0;
            offset     <= 3'd0;
        end else if (scroll_cnt == CNT_W'(SCROLL_PERIOD - 1)) begin
            scroll_cnt <= '0;
            offset     <= offset + 3'd1;
        end else begin
            scroll_cnt <= scroll_cnt + 1'b1;
        end
    end
`else
    // No scrolling: the image is shown unshifted
    assign offset = 3'(SCROLL_PERIOD * 0);
`endif

endmodule
